// File: rtl/add8u_mon_pkg.sv
// Shared widths and FSM encoding for the approximate-adder error monitor.
package add8u_mon_pkg;

  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 16;

  localparam int RES_W     = W_DEF + 1;
  localparam int DIFF_W    = W_DEF + 2;
  localparam int ABS_SUM_W = CNT_W_DEF + W_DEF + 1;
  localparam int SGN_SUM_W = CNT_W_DEF + W_DEF + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/add8u_err_calc.sv
// Combinational error of one approximate sum: diff = approx - (a+b) and |diff|.
module add8u_err_calc #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W:0]   approx,
  output logic [W+1:0] diff,
  output logic [W:0]   abs_diff
);

  logic [W:0]   exact;
  logic [W+1:0] neg;

  // One extra bit over the result width holds the sign of diff; |diff| always fits W+1 bits.
  always_comb begin
    exact    = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, approx} - {1'b0, exact};
    neg      = '0 - diff;
    abs_diff = diff[W+1] ? neg[W:0] : diff[W:0];
  end

endmodule

// File: rtl/add8u_err_monitor.sv
// Streams (a, b, approx) samples, recomputes the exact sum and accumulates
// MAE/bias/WCE/EP statistics over a window of window_len samples.
module add8u_err_monitor
  import add8u_mon_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       window_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [W:0]             in_approx,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       sample_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W+W:0]       abs_err_sum,
  output logic [CNT_W+W+1:0]     sgn_err_sum,
  output logic [W:0]             wce,
  output logic [1:0]             fsm_state
);

  localparam int RW = W + 1;
  localparam int DW = W + 2;
  localparam int AW = CNT_W + W + 1;
  localparam int SW = CNT_W + W + 2;

  logic [1:0]       state;
  logic [CNT_W-1:0] len_q;
  logic             s1_valid;
  logic [DW-1:0]    s1_diff;
  logic [RW-1:0]    s1_abs;
  logic [DW-1:0]    calc_diff;
  logic [RW-1:0]    calc_abs;
  logic             accept;
  logic             start_ok;

  add8u_err_calc #(.W(W)) u_calc (
    .a        (in_a),
    .b        (in_b),
    .approx   (in_approx),
    .diff     (calc_diff),
    .abs_diff (calc_abs)
  );

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready.
  // in_ready is a pure decode of the state register, never of in_valid.
  assign in_ready  = (state == ST_RUN);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;
  assign accept    = in_ready && in_valid;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      s1_valid    <= 1'b0;
      s1_diff     <= '0;
      s1_abs      <= '0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      abs_err_sum <= '0;
      sgn_err_sum <= '0;
      wce         <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_diff <= calc_diff;
        s1_abs  <= calc_abs;
      end

      // Stage 2: fold the registered sample into the window statistics.
      if (s1_valid) begin
        abs_err_sum <= abs_err_sum + AW'(s1_abs);
        sgn_err_sum <= sgn_err_sum + {{(SW-DW){s1_diff[DW-1]}}, s1_diff};
        if (s1_diff != '0) err_cnt <= err_cnt + 1'b1;
        if (s1_abs > wce)  wce     <= s1_abs;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            len_q       <= window_len;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            abs_err_sum <= '0;
            sgn_err_sum <= '0;
            wce         <= '0;
            state       <= (window_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt + 1'b1 == len_q) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!s1_valid) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Directed-vector bench for add8u_err_monitor with hand-computed statistics.
module tb_add8u_err_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   window_len;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_a;
  logic [W-1:0]       in_b;
  logic [W:0]         in_approx;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic [CNT_W+W:0]   abs_err_sum;
  logic [CNT_W+W+1:0] sgn_err_sum;
  logic [W:0]         wce;
  logic [1:0]         fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  add8u_err_monitor #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .window_len  (window_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_approx   (in_approx),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .abs_err_sum (abs_err_sum),
    .sgn_err_sum (sgn_err_sum),
    .wce         (wce),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_window(input int len);
    start      = 1'b1;
    window_len = CNT_W'(len);
    step();
    start      = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int approx);
    in_valid  = 1'b1;
    in_a      = W'(a);
    in_b      = W'(b);
    in_approx = (W+1)'(approx);
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 10 && !done; i++) step();
    check({tag, "_done"}, done, 1);
  endtask

  task automatic check_stats(input string tag, input int sc, input int ec,
                             input int abs_s, input int sgn_s, input int w);
    check({tag, "_sample_cnt"}, sample_cnt, sc);
    check({tag, "_err_cnt"}, err_cnt, ec);
    check({tag, "_abs_err_sum"}, abs_err_sum, abs_s);
    check({tag, "_sgn_err_sum"}, $signed(sgn_err_sum), sgn_s);
    check({tag, "_wce"}, wce, w);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; window_len = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0;
    step(); step();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", fsm_state, S_IDLE);
    check_stats("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Exact sums only: no errors.
    start_window(4);
    check("exact_in_ready", in_ready, 1);
    check("exact_busy", busy, 1);
    send(3, 5, 8);
    send(255, 255, 510);
    send(0, 0, 0);
    send(128, 128, 256);
    wait_done("exact");
    check_stats("exact", 4, 0, 0, 0, 0);

    // Restart from DONE: diffs +1, -2, 0.
    start_window(3);
    check("restart_done_low", done, 0);
    check_stats("restart_clear", 0, 0, 0, 0, 0);
    send(10, 20, 31);
    send(100, 100, 198);
    send(7, 9, 16);
    wait_done("mixed");
    check_stats("mixed", 3, 2, 3, -1, 2);

    // Extremes: diff -510 then +511; the larger magnitude is 511.
    start_window(2);
    send(255, 255, 0);
    send(0, 0, 511);
    wait_done("extreme");
    check_stats("extreme", 2, 2, 1021, 1, 511);

    // Handshake timing with a gap in in_valid and a trailing extra sample.
    start_window(2);
    check("hs_ready_first", in_ready, 1);
    send(1, 2, 3);
    check("hs_cnt_1", sample_cnt, 1);
    step();
    check("hs_cnt_gap", sample_cnt, 1);
    check("hs_ready_gap", in_ready, 1);
    send(4, 4, 9);
    check("hs_ready_after_last", in_ready, 0);
    check("hs_cnt_2", sample_cnt, 2);
    check("hs_state_drain", fsm_state, S_DRAIN);
    check("hs_done_plus1", done, 0);
    send(50, 50, 7);
    check("hs_done_plus2_pre", done, 0);
    check("hs_busy_drain", busy, 1);
    step();
    check("hs_done_two_after", done, 1);
    check("hs_busy_done", busy, 0);
    check_stats("hs", 2, 1, 1, 1, 1);

    // Zero-length window goes straight to DONE.
    start_window(0);
    check("zero_done", done, 1);
    check("zero_ready", in_ready, 0);
    check_stats("zero", 0, 0, 0, 0, 0);
    send(9, 9, 1);
    check("zero_ready_later", in_ready, 0);
    check("zero_cnt_later", sample_cnt, 0);

    // start during RUN must not relatch the length or clear stats.
    start_window(3);
    send(2, 2, 5);
    start = 1'b1; window_len = CNT_W'(1);
    send(6, 6, 12);
    start = 1'b0;
    check("run_start_busy", busy, 1);
    check("run_start_cnt", sample_cnt, 2);
    send(20, 30, 46);
    wait_done("run_start");
    check_stats("run_start", 3, 2, 5, -3, 4);

    // Reset mid-window discards everything.
    start_window(5);
    send(1, 1, 3);
    send(2, 2, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", fsm_state, S_IDLE);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check_stats("mid_rst", 0, 0, 0, 0, 0);
    start_window(1);
    send(40, 2, 40);
    wait_done("post_rst");
    check_stats("post_rst", 1, 1, 2, -2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
